fifo_write_arbiter: RTL and testbench

Shares the single write port of the team's async FIFO among NUM_REQUESTERS valid/ready sources, in the FIFO's write clock domain. Round-robin arbitration grants one requester at a time for a burst. A burst ends on packet end, on the burst cap, or on a stall timeout. Each FIFO word is tagged with the source ID and a last flag so the read side can demultiplex interleaved packets.

---
 rtl/fifo_write_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port.
// Words are tagged {last, id, data} for read-side demultiplexing.
module fifo_write_arbiter #(
   parameter int NUM_REQUESTERS = 4,
   parameter int WIDTH          = 32,
   parameter int MAX_BURST      = 8,
   parameter int STALL_TIMEOUT  = 4,
   localparam int ID_WIDTH =
      (NUM_REQUESTERS > 2) ? $clog2(NUM_REQUESTERS) : 1,
   localparam int FIFO_WIDTH = 1 + ID_WIDTH + WIDTH
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_REQUESTERS-1:0]       req_valid,
   input  logic [NUM_REQUESTERS*WIDTH-1:0] req_data,
   input  logic [NUM_REQUESTERS-1:0]       req_last,
   output logic [NUM_REQUESTERS-1:0]       req_ready,
   input  logic                            fifo_full,
   output logic                            fifo_write_en,
   output logic [FIFO_WIDTH-1:0]           fifo_write_data,
   output logic [ID_WIDTH-1:0]             grant_id,
   output logic                            busy
);

   localparam int BEAT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int STALL_W =
      (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] rr_next;
   logic [ID_WIDTH-1:0] winner;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [STALL_W-1:0]  stall_cnt;
   logic                g_valid;
   logic                g_last;
   logic [WIDTH-1:0]    g_data;
   logic                in_burst;
   logic                xfer;
   logic                stalled;
   logic                burst_done;
   int                  idx;
   logic                found;

   assign in_burst = (state == BURST);
   assign g_valid  = req_valid[grant_id];
   assign g_last   = req_last[grant_id];
   assign g_data   = req_data[int'(grant_id)*WIDTH +: WIDTH];

   // A full FIFO freezes the burst: no transfer and no stall count.
   assign xfer    = in_burst & g_valid & ~fifo_full;
   assign stalled = in_burst & ~g_valid & ~fifo_full;

   assign burst_done =
      (xfer & (g_last | (beat_cnt == BEAT_W'(MAX_BURST-1)))) |
      (stalled & (stall_cnt == STALL_W'(STALL_TIMEOUT-1)));

   assign rr_next =
      (grant_id == ID_WIDTH'(NUM_REQUESTERS-1)) ? '0
                                                : grant_id + 1'b1;

   // First valid source scanning upward from rr_ptr, wrapping.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQUESTERS)
            idx = idx - NUM_REQUESTERS;
         if (!found && req_valid[idx[ID_WIDTH-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_WIDTH-1:0];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state: arbitrate in IDLE, leave BURST on any release cause.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|req_valid) state_nxt = BURST;
         BURST:   if (burst_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: only the granted source sees ready, gated by full.
   always_comb begin
      req_ready = '0;
      if (in_burst)
         req_ready[grant_id] = ~fifo_full;
      fifo_write_en   = xfer;
      fifo_write_data = {g_last, grant_id, g_data};
      busy            = in_burst;
   end

   // Grant, round-robin pointer and per-burst counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_id  <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else if (!in_burst) begin
         if (|req_valid) begin
            grant_id  <= winner;
            beat_cnt  <= '0;
            stall_cnt <= '0;
         end
      end else if (burst_done) begin
         rr_ptr    <= rr_next;
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else if (xfer) begin
         beat_cnt  <= beat_cnt + 1'b1;
         stall_cnt <= '0;
      end else if (stalled) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (N=4, W=32, burst 8, timeout 4).
// Immediate assertions compare against hand-computed expectations.
module tb_fifo_write_arbiter;

   logic         clk;
   logic         reset_n;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_last;
   logic [3:0]   req_ready;
   logic         fifo_full;
   logic         fifo_write_en;
   logic [34:0]  fifo_write_data;
   logic [1:0]   grant_id;
   logic         busy;

   int n_asserts = 0;
   int n_fail    = 0;

   fifo_write_arbiter dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_last        (req_last),
      .req_ready       (req_ready),
      .fifo_full       (fifo_full),
      .fifo_write_en   (fifo_write_en),
      .fifo_write_data (fifo_write_data),
      .grant_id        (grant_id),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic src(input int i, input logic v,
                      input logic [31:0] d, input logic l);
      req_valid[i]         = v;
      req_data[i*32 +: 32] = d;
      req_last[i]          = l;
   endtask

   task automatic do_reset();
      req_valid = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      reset_n   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   logic [1:0]  e;
   logic [34:0] w;

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;

      // 1: reset with all sources valid
      for (int i = 0; i < 4; i++) src(i, 1'b1, 32'h10 + i, 1'b0);
      tick();
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_wen", fifo_write_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_gid", grant_id, 2'd0);
      reset_n = 1'b1;
      #1;
      chk("rel_busy", busy, 1'b0);
      tick();
      chk("t1_busy", busy, 1'b1);
      chk("t1_gid", grant_id, 2'd0);
      chk("t1_ready", req_ready, 4'b0001);
      chk("t1_wdata", fifo_write_data, {1'b0, 2'd0, 32'h10});

      // 2: lone source 2, three-word packet
      do_reset();
      src(2, 1'b1, 32'hA1, 1'b0);
      #1;
      chk("t2_idle_busy", busy, 1'b0);
      chk("t2_idle_wen", fifo_write_en, 1'b0);
      tick();
      chk("t2_busy", busy, 1'b1);
      chk("t2_ready", req_ready, 4'b0100);
      chk("t2_wen0", fifo_write_en, 1'b1);
      chk("t2_w0", fifo_write_data, {1'b0, 2'd2, 32'hA1});
      tick();
      src(2, 1'b1, 32'hA2, 1'b0);
      #1;
      chk("t2_wen1", fifo_write_en, 1'b1);
      chk("t2_w1", fifo_write_data, {1'b0, 2'd2, 32'hA2});
      tick();
      src(2, 1'b1, 32'hA3, 1'b1);
      #1;
      chk("t2_wen2", fifo_write_en, 1'b1);
      chk("t2_w2", fifo_write_data, {1'b1, 2'd2, 32'hA3});
      tick();
      src(2, 1'b0, 32'h0, 1'b0);
      #1;
      chk("t2_end_busy", busy, 1'b0);
      chk("t2_end_wen", fifo_write_en, 1'b0);
      for (int i = 0; i < 4; i++) src(i, 1'b1, 32'h0, 1'b0);
      tick();
      chk("t2_rr3", grant_id, 2'd3);

      // 3: all sources endless, burst cap rotates the grant
      do_reset();
      for (int i = 0; i < 4; i++) src(i, 1'b1, 32'hC0 + i, 1'b0);
      #1;
      for (int g = 0; g < 5; g++) begin
         e = 2'(g % 4);
         chk($sformatf("t3_idle%0d", g), busy, 1'b0);
         chk($sformatf("t3_idlew%0d", g), fifo_write_en, 1'b0);
         tick();
         for (int b = 0; b < 8; b++) begin
            w = {1'b0, e, 32'hC0 + 32'(e)};
            chk($sformatf("t3_g%0d_b%0d_gid", g, b), grant_id, e);
            chk($sformatf("t3_g%0d_b%0d_wen", g, b), fifo_write_en, 1'b1);
            chk($sformatf("t3_g%0d_b%0d_wd", g, b), fifo_write_data, w);
            tick();
         end
      end

      // 4: backpressure on source 1
      do_reset();
      src(1, 1'b1, 32'hD0, 1'b0);
      tick();
      chk("t4_gid", grant_id, 2'd1);
      chk("t4_wen0", fifo_write_en, 1'b1);
      tick();
      src(1, 1'b1, 32'hD1, 1'b0);
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("t4_full_wen%0d", c), fifo_write_en, 1'b0);
         chk($sformatf("t4_full_rdy%0d", c), req_ready, 4'b0000);
         chk($sformatf("t4_full_busy%0d", c), busy, 1'b1);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("t4_resume_wen", fifo_write_en, 1'b1);
      chk("t4_resume_wd", fifo_write_data, {1'b0, 2'd1, 32'hD1});
      tick();
      src(1, 1'b0, 32'hD2, 1'b0);
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("t4_fullidle_busy%0d", c), busy, 1'b1);
         tick();
      end
      fifo_full = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("t4_low_busy%0d", c), busy, 1'b1);
         tick();
      end
      src(1, 1'b1, 32'hD2, 1'b0);
      #1;
      chk("t4_after_wen", fifo_write_en, 1'b1);
      chk("t4_after_wd", fifo_write_data, {1'b0, 2'd1, 32'hD2});

      // 5: stall timeout on source 1, source 2 waiting
      do_reset();
      src(1, 1'b1, 32'hE0, 1'b0);
      src(2, 1'b1, 32'hF0, 1'b0);
      tick();
      chk("t5_gid", grant_id, 2'd1);
      chk("t5_wen0", fifo_write_en, 1'b1);
      tick();
      src(1, 1'b0, 32'hE1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("t5_gap_busy%0d", c), busy, 1'b1);
         chk($sformatf("t5_gap_wen%0d", c), fifo_write_en, 1'b0);
         tick();
      end
      src(1, 1'b1, 32'hE1, 1'b0);
      #1;
      chk("t5_resume_gid", grant_id, 2'd1);
      chk("t5_resume_wd", fifo_write_data, {1'b0, 2'd1, 32'hE1});
      chk("t5_resume_wen", fifo_write_en, 1'b1);
      tick();
      src(1, 1'b0, 32'hE2, 1'b0);
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("t5_to_busy%0d", c), busy, 1'b1);
         tick();
      end
      chk("t5_released", busy, 1'b0);
      tick();
      chk("t5_next_busy", busy, 1'b1);
      chk("t5_next_gid", grant_id, 2'd2);

      // 6: async reset mid-burst of source 3
      do_reset();
      src(3, 1'b1, 32'hB0, 1'b0);
      tick();
      chk("t6_gid", grant_id, 2'd3);
      tick();
      tick();
      chk("t6_beat3_wen", fifo_write_en, 1'b1);
      chk("t6_beat3_rdy", req_ready, 4'b1000);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_async_wen", fifo_write_en, 1'b0);
      chk("t6_async_rdy", req_ready, 4'b0000);
      chk("t6_async_busy", busy, 1'b0);
      src(0, 1'b1, 32'hB8, 1'b0);
      tick();
      reset_n = 1'b1;
      #1;
      tick();
      chk("t6_rr_gid", grant_id, 2'd0);
      chk("t6_rr_wd", fifo_write_data, {1'b0, 2'd0, 32'hB8});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fail);
      $finish;
   end

endmodule
